wrr_arbiter: RTL



---
 rtl/wrr_arbiter.sv | 73 +++++++
 1 files changed

// File: rtl/wrr_arbiter.sv
// wrr_arbiter: weighted round-robin arbiter; each winner holds the grant for up to
// weight[i] consecutive cycles while requesting, then priority rotates past it.
module wrr_arbiter #(
  parameter int N = 32,
  parameter int IDW = 5,
  parameter int WW = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic           cfg_we,
  input  logic [IDW-1:0] cfg_id,
  input  logic [WW-1:0]  cfg_weight,
  output logic [N-1:0]   gnt_w,
  output logic [IDW-1:0] gnt_id,
  output logic           gnt_valid
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t         state, state_nx;
  logic [WW-1:0]  weight [N];
  logic [WW-1:0]  credit, credit_nx;
  logic [IDW-1:0] ptr, ptr_nx, win, gnt_id_nx;
  logic [N-1:0]   eligible, gnt_w_nx;
  logic           found, rearb, valid_nx;

  for (genvar i = 0; i < N; i++) begin : g_elig
    assign eligible[i] = req[i] && weight[i] != '0;
  end

  // Scan from the far end so the last hit is the first eligible after ptr;
  // k = N lands back on ptr, letting a lone owner be regranted.
  always_comb begin
    found = 1'b0;
    win = ptr;
    for (int k = N; k > 0; k--) begin
      if (eligible[(int'(ptr) + k) % N]) begin
        found = 1'b1;
        win = IDW'((int'(ptr) + k) % N);
      end
    end
  end

  assign rearb = state == IDLE || !req[ptr] || credit == WW'(1);

  always_comb begin
    state_nx = rearb ? (found ? GRANT : IDLE) : state;
    credit_nx = rearb ? (found ? weight[win] : '0) : credit - WW'(1);
    ptr_nx = rearb && found ? win : ptr;
    gnt_w_nx = rearb ? (found ? N'(1) << win : '0) : gnt_w;
    gnt_id_nx = rearb ? (found ? win : '0) : gnt_id;
    valid_nx = rearb ? found : gnt_valid;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      credit <= '0;
      ptr <= IDW'(N - 1);
      gnt_w <= '0;
      gnt_id <= '0;
      gnt_valid <= 1'b0;
      for (int i = 0; i < N; i++) weight[i] <= WW'(1);
    end else begin
      state <= state_nx;
      credit <= credit_nx;
      ptr <= ptr_nx;
      gnt_w <= gnt_w_nx;
      gnt_id <= gnt_id_nx;
      gnt_valid <= valid_nx;
      if (cfg_we) weight[cfg_id] <= cfg_weight;
    end
  end
endmodule
